// File: rtl/ysyx_24100012_partial_store.sv
// Store unit: turns one sb/sh/sw request into one or two word-aligned, byte-strobed write beats.
// Latency: done 3 cycles after accept (one beat), 5 (two beats), 1 (illegal funct3) with zero-wait memory.
// Backpressure: req_ready only in IDLE; each beat holds until mem_wready, then waits for mem_bvalid.
module ysyx_24100012_partial_store #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [3:0]            func7_6_func3,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  mem_wvalid,
    input  logic                  mem_wready,
    output logic [ADDR_WIDTH-1:0] mem_waddr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic [3:0]            mem_wstrb,
    input  logic                  mem_bvalid,
    output logic                  mem_bready,
    output logic                  done,
    output logic                  err
);

    typedef enum logic [2:0] {S_IDLE, S_W0, S_B0, S_W1, S_B1, S_DONE} state_e;

    state_e                  state_q, state_d;
    logic                    err_q, err_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [DATA_WIDTH-1:0]   hi_data_q, hi_data_d;
    logic [3:0]              hi_strb_q, hi_strb_d;

    logic                    accept;
    logic                    legal;
    logic [DATA_WIDTH-1:0]   byte_mask;
    logic [3:0]              lane_mask;
    logic [2*DATA_WIDTH-1:0] data_sh;
    logic [7:0]              strb_sh;
    logic                    unused_func_bit3;

    assign unused_func_bit3 = func7_6_func3[3];
    assign accept           = req_valid && (state_q == S_IDLE);
    assign legal            = (func7_6_func3[2:0] <= 3'b010);

    always_comb begin
        byte_mask = DATA_WIDTH'(32'hFFFF_FFFF);
        lane_mask = 4'b1111;
        case (func7_6_func3[2:0])
            3'b000: begin
                byte_mask = DATA_WIDTH'(32'h0000_00FF);
                lane_mask = 4'b0001;
            end
            3'b001: begin
                byte_mask = DATA_WIDTH'(32'h0000_FFFF);
                lane_mask = 4'b0011;
            end
            default: ;
        endcase
    end

    // Lanes shifted past bit 31 / strobe bit 3 spill into the second beat.
    assign data_sh = {{DATA_WIDTH{1'b0}}, wdata & byte_mask} << {addr[1:0], 3'b000};
    assign strb_sh = {4'b0000, lane_mask} << addr[1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = legal ? S_W0 : S_DONE;
            S_W0:   if (mem_wready) state_d = S_B0;
            S_B0:   if (mem_bvalid) state_d = (hi_strb_q != 4'b0000) ? S_W1 : S_DONE;
            S_W1:   if (mem_wready) state_d = S_B1;
            S_B1:   if (mem_bvalid) state_d = S_DONE;
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        err_d     = err_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        hi_data_d = hi_data_q;
        hi_strb_d = hi_strb_q;
        if (accept) begin
            err_d = !legal;
            if (legal) begin
                waddr_d   = {addr[ADDR_WIDTH-1:2], 2'b00};
                wdata_d   = data_sh[DATA_WIDTH-1:0];
                wstrb_d   = strb_sh[3:0];
                hi_data_d = data_sh[2*DATA_WIDTH-1:DATA_WIDTH];
                hi_strb_d = strb_sh[7:4];
            end
        end else if (state_q == S_B0 && mem_bvalid && hi_strb_q != 4'b0000) begin
            waddr_d = waddr_q + ADDR_WIDTH'(4);
            wdata_d = hi_data_q;
            wstrb_d = hi_strb_q;
        end else if (state_q == S_DONE) begin
            err_d     = 1'b0;
            waddr_d   = '0;
            wdata_d   = '0;
            wstrb_d   = '0;
            hi_data_d = '0;
            hi_strb_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            err_q     <= 1'b0;
            waddr_q   <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            hi_data_q <= '0;
            hi_strb_q <= '0;
        end else begin
            state_q   <= state_d;
            err_q     <= err_d;
            waddr_q   <= waddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            hi_data_q <= hi_data_d;
            hi_strb_q <= hi_strb_d;
        end
    end

    always_comb begin
        req_ready  = (state_q == S_IDLE);
        mem_wvalid = (state_q == S_W0) || (state_q == S_W1);
        mem_bready = (state_q == S_B0) || (state_q == S_B1);
        done       = (state_q == S_DONE);
        err        = (state_q == S_DONE) && err_q;
        mem_waddr  = waddr_q;
        mem_wdata  = wdata_q;
        mem_wstrb  = wstrb_q;
    end

endmodule

// File: tb/tb_ysyx_24100012_partial_store.sv
// Bench for ysyx_24100012_partial_store: byte-wise store model feeds a scoreboard of beats and done/err pulses.
module tb_ysyx_24100012_partial_store;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  f3v = 4'd0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        mem_wvalid;
    logic        mem_wready = 1'b0;
    logic [31:0] mem_waddr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_bvalid = 1'b0;
    logic        mem_bready;
    logic        done;
    logic        err;

    ysyx_24100012_partial_store #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .func7_6_func3(f3v), .addr(addr), .wdata(wdata),
        .mem_wvalid(mem_wvalid), .mem_wready(mem_wready),
        .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_bvalid(mem_bvalid), .mem_bready(mem_bready),
        .done(done), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
    } beat_t;

    beat_t exp_beats[$];
    bit    exp_err[$];
    int    tests = 0;
    int    fails = 0;

    bit    mem_auto   = 1'b1;
    bit    zero_wait  = 1'b1;
    bit    spurious_b = 1'b0;
    int    stall_req  = 0;

    // Memory side: zero-wait, randomly delayed (with stray wready/bvalid), or manual.
    always @(posedge clk) begin
        #1;
        if (!mem_auto) begin
            mem_wready = mem_wvalid;
            mem_bvalid = spurious_b;
        end else begin
            if (stall_req > 0 && mem_wvalid) begin
                mem_wready = 1'b0;
                stall_req  = stall_req - 1;
            end else if (zero_wait) begin
                mem_wready = mem_wvalid;
            end else begin
                mem_wready = ($urandom_range(0, 2) == 0);
            end
            mem_bvalid = zero_wait ? mem_bready : ($urandom_range(0, 2) == 0);
        end
    end

    beat_t mon_act, mon_exp, prev_b;
    bit    prev_stall = 1'b0;
    bit    mon_ee;

    always @(negedge clk) begin
        if (!rst) begin
            prev_stall = 1'b0;
        end else begin
            mon_act = '{a: mem_waddr, d: mem_wdata, s: mem_wstrb};
            if (prev_stall) begin
                tests++;
                if (!mem_wvalid || mon_act != prev_b) begin
                    fails++;
                    $display("FAIL beat_hold: vld=%0b a=%h d=%h s=%b, held a=%h d=%h s=%b",
                             mem_wvalid, mon_act.a, mon_act.d, mon_act.s, prev_b.a, prev_b.d, prev_b.s);
                end
            end
            prev_stall = mem_wvalid && !mem_wready;
            prev_b     = mon_act;
            if (mem_wvalid && mem_wready) begin
                tests++;
                if (exp_beats.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_beat: a=%h d=%h s=%b, none expected", mon_act.a, mon_act.d, mon_act.s);
                end else begin
                    mon_exp = exp_beats.pop_front();
                    if (mon_act != mon_exp) begin
                        fails++;
                        $display("FAIL beat: got a=%h d=%h s=%b, want a=%h d=%h s=%b",
                                 mon_act.a, mon_act.d, mon_act.s, mon_exp.a, mon_exp.d, mon_exp.s);
                    end
                end
            end
            if (done || err) begin
                tests++;
                if (!done) begin
                    fails++;
                    $display("FAIL err_without_done: err=%0b done=%0b, want done=1", err, done);
                end else if (exp_err.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_done: done=%0b err=%0b, none expected", done, err);
                end else begin
                    mon_ee = exp_err.pop_front();
                    if (err != mon_ee) begin
                        fails++;
                        $display("FAIL done_err: err=%0b, want %0b", err, mon_ee);
                    end
                end
            end
        end
    end

    // Reference: place each stored byte at its own address, grouped by the word it lands in.
    task automatic push_model(input logic [3:0] f, input logic [31:0] a, input logic [31:0] d,
                              input bit with_done);
        int          n;
        int          lane;
        beat_t       b0, b1;
        logic [31:0] ba;
        if (f[2:0] > 3'd2) begin
            if (with_done) exp_err.push_back(1'b1);
            return;
        end
        n  = (f[2:0] == 3'd0) ? 1 : (f[2:0] == 3'd1) ? 2 : 4;
        b0 = '0;
        b1 = '0;
        b0.a = a & ~32'h3;
        b1.a = b0.a + 32'd4;
        for (int i = 0; i < n; i++) begin
            ba   = a + 32'(i);
            lane = int'(ba[1:0]);
            if ((ba & ~32'h3) == b0.a) begin
                b0.d[8*lane +: 8] = d[8*i +: 8];
                b0.s[lane] = 1'b1;
            end else begin
                b1.d[8*lane +: 8] = d[8*i +: 8];
                b1.s[lane] = 1'b1;
            end
        end
        exp_beats.push_back(b0);
        if (b1.s != 4'b0000) exp_beats.push_back(b1);
        if (with_done) exp_err.push_back(1'b0);
    endtask

    task automatic issue(input logic [3:0] f, input logic [31:0] a, input logic [31:0] d,
                         input bit with_done);
        int w = 0;
        @(negedge clk);
        while (!req_ready && w < 200) begin
            @(negedge clk);
            w++;
        end
        tests++;
        if (!req_ready) begin
            fails++;
            $display("FAIL issue_ready: req_ready=%0b after %0d cycles, want 1", req_ready, w);
        end
        push_model(f, a, d, with_done);
        req_valid = 1'b1;
        f3v       = f;
        addr      = a;
        wdata     = d;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        f3v       = 4'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
    endtask

    task automatic wait_done(input int exp_lat, input string name);
        int lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 300);
        tests++;
        if (!done) begin
            fails++;
            $display("FAIL %s_timeout: done=%0b after %0d cycles, want 1", name, done, lat);
        end else if (exp_lat > 0 && lat != exp_lat) begin
            fails++;
            $display("FAIL %s_latency: done at N+%0d, want N+%0d", name, lat, exp_lat);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          w;
        int          r;
        logic [3:0]  f;
        logic [31:0] a;

        repeat (2) @(negedge clk);
        tests++;
        if (mem_wvalid || mem_bready || done || err || mem_waddr != 0 || mem_wdata != 0
            || mem_wstrb != 0 || !req_ready) begin
            fails++;
            $display("FAIL reset_state: wv=%0b br=%0b dn=%0b er=%0b a=%h d=%h s=%b rdy=%0b, want all 0, rdy=1",
                     mem_wvalid, mem_bready, done, err, mem_waddr, mem_wdata, mem_wstrb, req_ready);
        end
        rst = 1'b1;

        issue(4'b0010, 32'h8000_0010, 32'hDEAD_BEEF, 1'b1);
        wait_done(3, "sw_aligned");
        issue(4'b0000, 32'h8000_0013, 32'h1234_56AB, 1'b1);
        wait_done(3, "sb_lane3");
        issue(4'b0001, 32'h8000_0003, 32'hFFFF_BEEF, 1'b1);
        wait_done(5, "sh_split");

        stall_req = 3;
        issue(4'b0010, 32'h8000_0006, 32'h1122_3344, 1'b1);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            req_valid = 1'b1;
            f3v       = 4'b0000;
            addr      = 32'h0000_0100;
            wdata     = 32'h0000_0055;
            tests++;
            if (req_ready) begin
                fails++;
                $display("FAIL busy_ready: req_ready=%0b, want 0", req_ready);
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        wait_done(-1, "sw_stalled");

        issue(4'b0011, 32'h8000_0020, 32'hAAAA_5555, 1'b1);
        wait_done(1, "illegal");
        @(negedge clk);
        tests++;
        if (!req_ready) begin
            fails++;
            $display("FAIL illegal_ready: req_ready=%0b at N+2, want 1", req_ready);
        end

        mem_auto = 1'b0;
        issue(4'b0010, 32'h8000_0020, 32'hCAFE_F00D, 1'b0);
        w = 0;
        while (!mem_bready && w < 50) begin
            @(negedge clk);
            w++;
        end
        #1 rst = 1'b0;
        #1;
        tests++;
        if (mem_wvalid || mem_bready || done || err || mem_waddr != 0 || mem_wdata != 0
            || mem_wstrb != 0 || !req_ready) begin
            fails++;
            $display("FAIL midreset: wv=%0b br=%0b dn=%0b er=%0b a=%h d=%h s=%b rdy=%0b, want all 0, rdy=1",
                     mem_wvalid, mem_bready, done, err, mem_waddr, mem_wdata, mem_wstrb, req_ready);
        end
        @(negedge clk);
        rst        = 1'b1;
        spurious_b = 1'b1;
        repeat (3) @(negedge clk);
        spurious_b = 1'b0;
        repeat (2) @(negedge clk);
        mem_auto  = 1'b1;
        zero_wait = 1'b1;
        issue(4'b0010, 32'h8000_0040, 32'h0BAD_F00D, 1'b1);
        wait_done(3, "after_reset");

        zero_wait = 1'b0;
        for (int t = 0; t < 60; t++) begin
            r = $urandom_range(0, 9);
            if (r < 3)      f = 4'b0000;
            else if (r < 6) f = 4'b0001;
            else if (r < 8) f = 4'b0010;
            else            f = 4'($urandom_range(3, 7));
            f[3] = 1'($urandom);
            a = $urandom;
            if ($urandom_range(0, 7) == 0) a = 32'hFFFF_FFFC | 32'($urandom_range(0, 3));
            issue(f, a, $urandom, 1'b1);
            wait_done(-1, "random");
        end

        repeat (5) @(negedge clk);
        tests++;
        if (exp_beats.size() != 0 || exp_err.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d beats and %0d dones outstanding, want 0 and 0",
                     exp_beats.size(), exp_err.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/ysyx_24100012_partial_store.md
Name: ysyx_24100012_partial_store

Overview:
Store-side counterpart of the partial-load path. Accepts one store request (sb/sh/sw) from the execute stage, builds byte-lane data and a write strobe, and drives a word-aligned write handshake to data memory. Stores that cross a word boundary are split into two aligned beats. Signals completion with a one-cycle done pulse.

Parameters:
ADDR_WIDTH, 32, byte address width.
DATA_WIDTH, 32, data/word width; only 32 is supported (4 byte lanes).

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-low.
req_valid  in  1  store request present.
req_ready  out  1  unit can accept a request.
func7_6_func3  in  4  bits [2:0] = funct3: 000 sb, 001 sh, 010 sw; all other values illegal; bit 3 ignored.
addr  in  ADDR_WIDTH  byte address, any alignment.
wdata  in  DATA_WIDTH  store data, LSB-justified.
mem_wvalid  out  1  write beat valid.
mem_wready  in  1  memory accepts beat.
mem_waddr  out  ADDR_WIDTH  word-aligned beat address (bits [1:0] = 0).
mem_wdata  out  DATA_WIDTH  lane-positioned write data.
mem_wstrb  out  4  byte-lane enables.
mem_bvalid  in  1  write response for the accepted beat.
mem_bready  out  1  unit accepts the response.
done  out  1  one-cycle pulse at completion.
err  out  1  pulses with done for an illegal funct3.

Behaviour:
- Reset (rst=0, async): state IDLE. mem_wvalid, mem_bready, done, err, mem_waddr, mem_wdata, mem_wstrb = 0. req_ready = 1 (req_ready is (state==IDLE)). Reset mid-transaction abandons the store; no further beats are issued.
- Accept: a request is accepted when req_valid && req_ready are both high. At acceptance, func3, addr, and wdata are latched. req_valid is ignored outside IDLE.
- Size n: sb=1, sh=2, sw=4. off = addr[1:0]. mask = (1<<n)-1.
- Lane placement: D64 = zero-extend(wdata & byte-mask(n)) << (8*off). S8 = mask << off.
  - Beat0: addr = {addr[ADDR_WIDTH-1:2], 2'b00}, data = D64[31:0], strb = S8[3:0].
  - Beat1: only when S8[7:4] != 0. addr = beat0 addr + 4 (wraps modulo 2^ADDR_WIDTH), data = D64[63:32], strb = S8[7:4].
  - Unused lanes are driven as 0.
- FSM states: IDLE, W0, B0, W1, B1, DONE.
  - IDLE -> W0 on accept with legal funct3. IDLE -> DONE (err=1) on accept with illegal funct3; no memory activity occurs.
  - W0: mem_wvalid=1 with beat0 payload. On mem_wready -> B0.
  - B0: mem_bready=1. On mem_bvalid -> W1 if a second beat is needed, else DONE.
  - W1 / B1: same as W0 / B0 with beat1 payload. On mem_bvalid in B1 -> DONE.
  - DONE: done=1 (and err if the request was illegal) for exactly one cycle, then -> IDLE.
- Handshake rules:
  - mem_wvalid, once raised, stays high and mem_waddr/mem_wdata/mem_wstrb stay stable until mem_wready.
  - mem_wvalid never drops without mem_wready.
  - mem_bvalid is ignored outside B0/B1.
  - mem_wready outside W0/W1 is ignored.
- Latency: with zero-wait memory (wready in the first W cycle, bvalid in the first B cycle), accept at cycle N gives done at N+3 for one beat and N+5 for two beats. Illegal funct3: done at N+1.
- All outputs are registered or decoded from state only; there is no combinational path from req_* to mem_*.

Test Plan:
1. sw, addr 0x80000010, wdata 0xDEADBEEF, zero-wait memory -> single beat: waddr 0x80000010, wstrb 4'b1111, wdata 0xDEADBEEF. done at N+3, err=0.
2. sb, addr 0x80000013, wdata 0x123456AB -> single beat: waddr 0x80000010, wstrb 4'b1000, wdata 0xAB000000.
3. sh, addr 0x80000003, wdata 0xFFFFBEEF -> beat0: waddr 0x80000000, wstrb 4'b1000, wdata 0xEF000000. Beat1: waddr 0x80000004, wstrb 4'b0001, wdata 0x000000BE. done at N+5.
4. sw, addr 0x80000006, wdata 0x11223344, with mem_wready held low for 3 cycles in W0 -> beat0 (waddr 0x80000004, wstrb 4'b1100, wdata 0x33440000) stays stable while wvalid is held. Beat1: waddr 0x80000008, wstrb 4'b0011, wdata 0x00001122. req_ready=0 throughout, and a req_valid pulse during this time is ignored.
5. funct3=3'b011 -> no mem_wvalid; done=1 and err=1 at N+1; req_ready=1 at N+2.
6. rst driven low while in B0 -> all outputs 0 and req_ready=1 immediately. A spurious mem_bvalid after release produces no done. A new sw after release completes normally.
